// File: rtl/mini_alu_mc.sv
// mini_alu_mc -- multi-cycle mini ALU with a private register file.
//
// Accepts one instruction at a time (valid/ready handshake). Most ops take
// one EXEC cycle after accept; SMUL then spends DATA_W cycles in an
// iterative shift-add multiplier before writing back.
//
// Ports:
//   Clock, Reset         single clock, synchronous active-low reset
//   iInstValid/oInstReady instruction handshake (ready only in IDLE)
//   iOp, iDst, iSrc0/1   opcode, destination / branch target, sources
//   oLed                 registered LED value (low LED_W bits of a register)
//   oBranchTaken/Target  one-cycle branch pulse and its target
//   oRetire              one-cycle pulse per completed instruction
//
// Build option: define MINI_ALU_MC_SAT_EN to make ADD/SUB saturate to the
// signed DATA_W range instead of wrapping. SMUL always wraps.
module mini_alu_mc #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int LED_W  = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iInstValid,
   output logic              oInstReady,
   input  logic [3:0]        iOp,
   input  logic [ADDR_W-1:0] iDst,
   input  logic [ADDR_W-1:0] iSrc0,
   input  logic [ADDR_W-1:0] iSrc1,
   output logic [LED_W-1:0]  oLed,
   output logic              oBranchTaken,
   output logic [ADDR_W-1:0] oBranchTarget,
   output logic              oRetire
);

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SMUL = 4'd3;
   localparam logic [3:0] OP_STO  = 4'd4;
   localparam logic [3:0] OP_BLE  = 4'd5;
   localparam logic [3:0] OP_JMP  = 4'd6;
   localparam logic [3:0] OP_LED  = 4'd7;
   localparam int         CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

   state_t              state, stateNext;
   logic [3:0]          opR;
   logic [ADDR_W-1:0]   dstR, src0R, src1R;
   logic [DATA_W-1:0]   regFile [2**ADDR_W];
   logic [DATA_W-1:0]   opA, opB;           // opA = R[src0], opB = R[src1]
   logic [DATA_W-1:0]   imm, addRes, subRes;
   logic [DATA_W-1:0]   mcand, mplier, acc, accNext;
   logic [CNT_W-1:0]    mulCnt;
   logic                accept, execEnd, mulLast;
   logic                wrEn;
   logic [DATA_W-1:0]   wrData;

   // ---------------- FSM ----------------
   always_ff @(posedge Clock) begin
      if (!Reset) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      oInstReady = 1'b0;
      case (state)
         IDLE: begin
            oInstReady = 1'b1;
            if (iInstValid) stateNext = EXEC;
         end
         EXEC:    stateNext = (opR == OP_SMUL) ? MUL : IDLE;
         MUL:     if (mulCnt == CNT_LAST) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign accept  = iInstValid && (state == IDLE);
   assign execEnd = (state == EXEC) && (opR != OP_SMUL);
   assign mulLast = (state == MUL) && (mulCnt == CNT_LAST);

   // Instruction fields are only captured on accept, so input changes while
   // busy are ignored.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         opR   <= '0;
         dstR  <= '0;
         src0R <= '0;
         src1R <= '0;
      end else if (accept) begin
         opR   <= iOp;
         dstR  <= iDst;
         src0R <= iSrc0;
         src1R <= iSrc1;
      end
   end

   // ---------------- datapath ----------------
   assign opA = regFile[src0R];
   assign opB = regFile[src1R];

   generate
      if (2*ADDR_W >= DATA_W) begin : g_immTrunc
         logic [2*ADDR_W-1:0] immCat;
         assign immCat = {src1R, src0R};
         assign imm    = immCat[DATA_W-1:0];
      end else begin : g_immExt
         assign imm = {{(DATA_W-2*ADDR_W){1'b0}}, src1R, src0R};
      end
   endgenerate

`ifdef MINI_ALU_MC_SAT_EN
   // One guard bit; overflow when the guard and the sign bit disagree.
   logic [DATA_W:0] addWide, subWide;
   assign addWide = {opB[DATA_W-1], opB} + {opA[DATA_W-1], opA};
   assign subWide = {opB[DATA_W-1], opB} - {opA[DATA_W-1], opA};

   function automatic logic [DATA_W-1:0] sat(input logic [DATA_W:0] w);
      if (w[DATA_W] != w[DATA_W-1])
         return w[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return w[DATA_W-1:0];
   endfunction

   assign addRes = sat(addWide);
   assign subRes = sat(subWide);
`else
   assign addRes = opB + opA;
   assign subRes = opB - opA;
`endif

   // Shift-add multiplier. Only the low DATA_W product bits are kept, and
   // those are identical for signed and unsigned operands, so no sign
   // correction step is needed.
   assign accNext = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         mulCnt <= '0;
      end else if (state == EXEC) begin
         mcand  <= opA;
         mplier <= opB;
         acc    <= '0;
         mulCnt <= '0;
      end else if (state == MUL) begin
         acc    <= accNext;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         mulCnt <= mulCnt + 1'b1;
      end
   end

   // Register-file write. Gated by Reset so an aborted instruction never
   // commits. Sources are read combinationally before the write edge, so
   // dst == src is safe.
   always_comb begin
      wrEn   = 1'b0;
      wrData = accNext;
      if (Reset) begin
         if (execEnd) begin
            case (opR)
               OP_ADD: begin wrEn = 1'b1; wrData = addRes; end
               OP_SUB: begin wrEn = 1'b1; wrData = subRes; end
               OP_STO: begin wrEn = 1'b1; wrData = imm;    end
               default: ;
            endcase
         end else if (mulLast) begin
            wrEn = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (wrEn) regFile[dstR] <= wrData;
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         oLed          <= '0;
         oBranchTaken  <= 1'b0;
         oBranchTarget <= '0;
         oRetire       <= 1'b0;
      end else begin
         oRetire      <= execEnd | mulLast;
         oBranchTaken <= 1'b0;
         if (execEnd) begin
            case (opR)
               OP_BLE: if ($signed(opB) <= $signed(opA)) begin
                  oBranchTaken  <= 1'b1;
                  oBranchTarget <= dstR;
               end
               OP_JMP: begin
                  oBranchTaken  <= 1'b1;
                  oBranchTarget <= dstR;
               end
               OP_LED: oLed <= opB[LED_W-1:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/mini_alu_mc.md
MINI_ALU_MC -- requirements
Module: mini_alu_mc

Interface
REQ-001 Parameter DATA_W, default 16: datapath and register width in bits (legal 8..32).
REQ-002 Parameter ADDR_W, default 8: register-file address width, so depth is 2^ADDR_W.
REQ-003 Parameter LED_W, default 8: LED output width (LED_W <= DATA_W).
REQ-004 Clock  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-006 iInstValid  input  1  instruction offered.
REQ-007 oInstReady  output  1  block can accept an instruction.
REQ-008 iOp  input  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 SMUL, 4 STO, 5 BLE, 6 JMP, 7 LED; 8..15 behave as NOP.
REQ-009 iDst  input  ADDR_W  destination register, or branch target for BLE/JMP.
REQ-010 iSrc0, iSrc1  input  ADDR_W each  source registers; for STO, {iSrc1,iSrc0} low DATA_W bits is the immediate.
REQ-011 oLed  output  LED_W  registered LED value.
REQ-012 oBranchTaken  output  1  one-cycle pulse when a branch is taken.
REQ-013 oBranchTarget  output  ADDR_W  target, valid while oBranchTaken=1.
REQ-014 oRetire  output  1  one-cycle pulse per completed instruction.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and MUL; oInstReady SHALL be 1 only in IDLE.
REQ-016 Accept happens on an edge with iInstValid=1 and oInstReady=1; on accept, op, dst and both src fields SHALL be latched and the FSM SHALL go IDLE->EXEC.
REQ-017 iOp/iDst/iSrc changes while oInstReady=0 SHALL have no effect.
REQ-018 In EXEC, operands SHALL be read from the register file using the latched addresses, with asynchronous read.
REQ-019 Non-SMUL ops SHALL complete at the end of EXEC: the write, LED or branch takes effect, oRetire=1 for the following cycle, and the FSM returns to IDLE. Accept-to-retire is 2 edges.
REQ-020 ADD SHALL write R[dst]=R[src1]+R[src0]; SUB SHALL write R[dst]=R[src1]-R[src0]; both modulo 2^DATA_W unless REQ-031 applies.
REQ-021 STO SHALL write R[dst]=immediate.
REQ-022 BLE SHALL pulse oBranchTaken with oBranchTarget=dst when signed R[src1] <= R[src0], with no register write.
REQ-023 JMP SHALL always pulse oBranchTaken with oBranchTarget=dst.
REQ-024 LED SHALL load oLed=R[src1][LED_W-1:0] and hold it until the next LED op or reset.
REQ-025 SMUL: EXEC SHALL load the operands, then MUL SHALL run exactly DATA_W iterative shift-add cycles of a signed DATA_W x DATA_W multiply; R[dst] SHALL receive the low DATA_W bits of the product (wrapping) on the last MUL edge, followed by oRetire. Accept-to-retire is DATA_W+2 edges.
REQ-026 If dst equals a src register, the src SHALL be read before the write; a following instruction SHALL always see the written value.
REQ-027 NOP and undefined opcodes SHALL retire with no side effects.

Reset
REQ-028 Reset=0 at a rising edge SHALL force: state IDLE, oInstReady=1 on the next cycle, oLed=0, oBranchTaken=0, oBranchTarget=0, oRetire=0, multiplier state cleared.
REQ-029 Reset during EXEC or MUL SHALL abort the instruction with no register write, branch or retire pulse.
REQ-030 Register-file contents are not reset; they are undefined until written.

Configuration
REQ-031 When macro MINI_ALU_MC_SAT_EN is defined, ADD and SUB SHALL saturate signed results to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; when undefined they SHALL wrap modulo 2^DATA_W. SMUL always wraps.

Verification
REQ-032 Reset low 2 cycles then high -> oInstReady=1, oLed=0, oBranchTaken=0, oRetire=0.
REQ-033 STO R1=0x0005, STO R2=0x0003, ADD R3=R2+R1, LED src1=R3 -> oLed=0x08, one oRetire per instruction, each retire 2 edges after its accept.
REQ-034 STO R1=0xFFFD (-3), STO R2=0x0007, SMUL R4 -> R4=0xFFEB (-21), retire 18 edges after accept, oInstReady=0 for the whole multiply.
REQ-035 STO R1=0x7FFF, R2=0x0001, ADD R5 -> R5=0x8000 without the macro, 0x7FFF with MINI_ALU_MC_SAT_EN.
REQ-036 BLE with R[src1]=2, R[src0]=2, dst=0x10 -> oBranchTaken pulses 1 cycle with oBranchTarget=0x10; with R[src1]=3 -> no pulse; JMP dst=0x20 -> pulse with target 0x20.
REQ-037 Reset asserted on the 5th MUL cycle of a SMUL to R6 (R6 previously 0x1234) -> R6 remains 0x1234, no oRetire, IDLE after reset.
